// File: rtl/game_sequencer_if.sv
// Port bundle between the game sequencer (slave) and whatever drives/observes it (master).
interface game_sequencer_if;
  logic        frame_tick;
  logic        start;
  logic        btn_up;
  logic        btn_down;
  logic [15:0] score_in;
  logic [31:0] ball_pos_fb;
  logic [31:0] ball_vel_fb;
  logic [31:0] left_pad_fb;
  logic [31:0] dimensions;
  logic [31:0] ball_pos;
  logic [31:0] ball_vel;
  logic [31:0] left_pad;
  logic [31:0] right_pad;
  logic        core_rst;
  logic [2:0]  state;
  logic [1:0]  winner;

  modport master (
    output frame_tick, start, btn_up, btn_down, score_in,
           ball_pos_fb, ball_vel_fb, left_pad_fb,
    input  dimensions, ball_pos, ball_vel, left_pad, right_pad,
           core_rst, state, winner
  );

  modport slave (
    input  frame_tick, start, btn_up, btn_down, score_in,
           ball_pos_fb, ball_vel_fb, left_pad_fb,
    output dimensions, ball_pos, ball_vel, left_pad, right_pad,
           core_rst, state, winner
  );
endinterface

// File: rtl/game_sequencer.sv
// Frame-level game controller: owns ball/paddle state, feeds the ping-pong core and
// latches its next-state outputs, and runs the serve/play/point/over flow.
module game_sequencer #(
  parameter int FIELD_W     = 640,
  parameter int FIELD_H     = 480,
  parameter int PADDLE_LEN  = 64,
  parameter int PADDLE_STEP = 4,
  parameter int SERVE_VX    = 2,
  parameter int SERVE_VY    = 1,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_DELAY = 30,
  parameter int WIN_SCORE   = 11
) (
  input logic             clk,
  input logic             rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [15:0] CX         = 16'(FIELD_W / 2);
  localparam logic [15:0] CY         = 16'(FIELD_H / 2);
  localparam logic [15:0] PAD_Y0     = 16'((FIELD_H - PADDLE_LEN) / 2);
  localparam logic [15:0] PAD_MAX    = 16'(FIELD_H - PADDLE_LEN);
  localparam logic [15:0] RIGHT_X    = 16'(FIELD_W - 16);
  localparam logic [15:0] LEFT_X     = 16'd8;
  localparam logic [15:0] VX_POS     = 16'(SERVE_VX);
  localparam logic [15:0] VX_NEG     = 16'(-SERVE_VX);
  localparam logic [15:0] VY         = 16'(SERVE_VY);
  localparam logic [15:0] SERVE_LAST = 16'(SERVE_DELAY - 1);
  localparam logic [15:0] POINT_LAST = 16'(POINT_DELAY - 1);
  localparam logic [7:0]  WIN_B      = 8'(WIN_SCORE);
  localparam logic [16:0] STEP17     = 17'(PADDLE_STEP);

  state_t      st;
  logic [31:0] ball_pos_q;
  logic [31:0] ball_vel_q;
  logic [31:0] left_pad_q;
  logic [15:0] ry;
  logic [1:0]  winner_q;
  logic        core_rst_q;
  logic [15:0] cnt;
  logic [15:0] shadow;
  logic        dir_neg;

  logic        score_ev;
  logic        hi_inc;
  logic        lo_inc;
  logic        win_hi;
  logic        win_lo;
  logic [16:0] ry_sum;
  logic [16:0] ry_dif;
  logic [15:0] ry_next;

  // The core's own score clear lands while core_rst is low, so that cycle is not a point.
  assign score_ev = core_rst_q && (bus.score_in != shadow);
  assign hi_inc   = bus.score_in[15:8] > shadow[15:8];
  assign lo_inc   = bus.score_in[7:0] > shadow[7:0];
  assign win_hi   = bus.score_in[15:8] >= WIN_B;
  assign win_lo   = bus.score_in[7:0] >= WIN_B;

  always_comb begin
    ry_sum  = {1'b0, ry} + STEP17;
    ry_dif  = {1'b0, ry} - STEP17;
    ry_next = ry;
    if (bus.btn_up && !bus.btn_down)
      ry_next = ry_dif[16] ? '0 : ry_dif[15:0];
    else if (bus.btn_down && !bus.btn_up)
      ry_next = (ry_sum > {1'b0, PAD_MAX}) ? PAD_MAX : ry_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= IDLE;
      ball_pos_q <= {CX, CY};
      ball_vel_q <= '0;
      left_pad_q <= {LEFT_X, PAD_Y0};
      ry         <= PAD_Y0;
      winner_q   <= '0;
      core_rst_q <= 1'b0;
      cnt        <= '0;
      shadow     <= '0;
      dir_neg    <= 1'b0;
    end else begin
      shadow     <= bus.score_in;
      core_rst_q <= 1'b1;

      if (score_ev && st != POINT) begin
        if (hi_inc)      dir_neg <= 1'b1;
        else if (lo_inc) dir_neg <= 1'b0;
      end

      if (bus.frame_tick && (st == SERVE || st == PLAY))
        ry <= ry_next;

      case (st)
        IDLE, OVER: begin
          if (bus.start) begin
            st         <= SERVE;
            cnt        <= '0;
            winner_q   <= '0;
            core_rst_q <= 1'b0;
          end
        end
        SERVE: begin
          ball_pos_q <= {CX, CY};
          ball_vel_q <= '0;
          if (bus.frame_tick) begin
            if (cnt == SERVE_LAST) begin
              ball_vel_q <= {(dir_neg ? VX_NEG : VX_POS), VY};
              st         <= PLAY;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        PLAY: begin
          if (score_ev) begin
            ball_pos_q <= {CX, CY};
            ball_vel_q <= '0;
            cnt        <= '0;
            st         <= POINT;
          end else if (bus.frame_tick) begin
            ball_pos_q <= bus.ball_pos_fb;
            ball_vel_q <= bus.ball_vel_fb;
            left_pad_q <= bus.left_pad_fb;
          end
        end
        POINT: begin
          if (win_hi || win_lo) begin
            st       <= OVER;
            winner_q <= win_hi ? 2'b10 : 2'b01;
          end else if (bus.frame_tick) begin
            if (cnt == POINT_LAST) begin
              st  <= SERVE;
              cnt <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.dimensions = {16'(FIELD_W), 16'(FIELD_H)};
  assign bus.ball_pos   = ball_pos_q;
  assign bus.ball_vel   = ball_vel_q;
  assign bus.left_pad   = left_pad_q;
  assign bus.right_pad  = {RIGHT_X, ry};
  assign bus.core_rst   = core_rst_q;
  assign bus.state      = st;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer with an in-bench game-rules model and directed anchors.
module tb_game_sequencer;
  localparam int W = 640, H = 480, PL = 64, STEP = 4, VXS = 2, VYS = 1;
  localparam int SD = 60, PD = 30, WIN = 11;
  localparam int PMAX = H - PL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(
    .FIELD_W(W), .FIELD_H(H), .PADDLE_LEN(PL), .PADDLE_STEP(STEP),
    .SERVE_VX(VXS), .SERVE_VY(VYS), .SERVE_DELAY(SD), .POINT_DELAY(PD),
    .WIN_SCORE(WIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: game rules in plain integers.
  int          m_st, m_ticks, m_ry, m_win, m_sh_hi, m_sh_lo;
  logic [31:0] m_pos, m_vel, m_left;
  bit          m_crst, m_dneg;

  function automatic logic [31:0] centre();
    return {16'(W / 2), 16'(H / 2)};
  endfunction

  always @(posedge clk) begin : model
    int hi, lo, n_st, n_ticks, n_ry, n_win;
    logic [31:0] n_pos, n_vel, n_left;
    bit ev, n_crst, n_dneg;
    hi = int'(bus.score_in[15:8]);
    lo = int'(bus.score_in[7:0]);
    if (!rst) begin
      m_st = 0; m_ticks = 0; m_ry = PMAX / 2; m_win = 0;
      m_pos = centre(); m_vel = 0; m_left = {16'd8, 16'(PMAX / 2)};
      m_crst = 0; m_dneg = 0; m_sh_hi = 0; m_sh_lo = 0;
    end else begin
      ev = m_crst && (hi != m_sh_hi || lo != m_sh_lo);
      n_st = m_st; n_ticks = m_ticks; n_ry = m_ry; n_win = m_win;
      n_pos = m_pos; n_vel = m_vel; n_left = m_left; n_crst = 1; n_dneg = m_dneg;
      if (ev && m_st != 3) begin
        if (hi > m_sh_hi)      n_dneg = 1;
        else if (lo > m_sh_lo) n_dneg = 0;
      end
      if (bus.frame_tick && (m_st == 1 || m_st == 2) && bus.btn_up != bus.btn_down) begin
        if (bus.btn_up) n_ry = (m_ry - STEP < 0) ? 0 : m_ry - STEP;
        else            n_ry = (m_ry + STEP > PMAX) ? PMAX : m_ry + STEP;
      end
      case (m_st)
        0, 4: if (bus.start) begin n_st = 1; n_ticks = 0; n_win = 0; n_crst = 0; end
        1: begin
          n_pos = centre(); n_vel = 0;
          if (bus.frame_tick) begin
            n_ticks = m_ticks + 1;
            if (n_ticks == SD) begin
              n_st = 2; n_ticks = 0;
              n_vel = {16'(m_dneg ? -VXS : VXS), 16'(VYS)};
            end
          end
        end
        2: begin
          if (ev) begin
            n_st = 3; n_ticks = 0; n_pos = centre(); n_vel = 0;
          end else if (bus.frame_tick) begin
            n_pos = bus.ball_pos_fb; n_vel = bus.ball_vel_fb; n_left = bus.left_pad_fb;
          end
        end
        3: begin
          if (hi >= WIN || lo >= WIN) begin
            n_st = 4; n_win = (hi >= WIN) ? 2 : 1;
          end else if (bus.frame_tick) begin
            n_ticks = m_ticks + 1;
            if (n_ticks == PD) begin n_st = 1; n_ticks = 0; end
          end
        end
        default: n_st = 0;
      endcase
      m_st = n_st; m_ticks = n_ticks; m_ry = n_ry; m_win = n_win;
      m_pos = n_pos; m_vel = n_vel; m_left = n_left; m_crst = n_crst; m_dneg = n_dneg;
      m_sh_hi = hi; m_sh_lo = lo;
    end
  end

  always @(negedge clk) begin : compare
    chk("state", 32'(bus.state), 32'(m_st));
    chk("ball_pos", bus.ball_pos, m_pos);
    chk("ball_vel", bus.ball_vel, m_vel);
    chk("left_pad", bus.left_pad, m_left);
    chk("right_pad", bus.right_pad, {16'(W - 16), 16'(m_ry)});
    chk("core_rst", 32'(bus.core_rst), 32'(m_crst));
    chk("winner", 32'(bus.winner), 32'(m_win));
    chk("dimensions", bus.dimensions, 32'h028001E0);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1; cyc();
      bus.frame_tick = 1'b0; cyc();
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ball_pos"}, bus.ball_pos, 32'h014000F0);
    chk({tag, "_ball_vel"}, bus.ball_vel, 32'h0);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_core_rst"}, 32'(bus.core_rst), 32'd0);
    chk({tag, "_winner"}, 32'(bus.winner), 32'd0);
    chk({tag, "_left_pad"}, bus.left_pad, 32'h000800D0);
    chk({tag, "_right_pad"}, bus.right_pad, 32'h027000D0);
  endtask

  initial begin : stim
    int hi, lo, r;
    bit did_rst, prev_tick;
    bus.frame_tick = 0; bus.start = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.score_in = 0; bus.ball_pos_fb = 0; bus.ball_vel_fb = 0;
    bus.left_pad_fb = 32'h000800D0;
    rst = 1'b0;
    repeat (3) cyc();
    check_reset_values("reset");
    rst = 1'b1; cyc();
    chk("core_rst_release", 32'(bus.core_rst), 32'd1);

    bus.start = 1; cyc(); bus.start = 0;
    chk("start_state", 32'(bus.state), 32'd1);
    chk("start_core_rst_low", 32'(bus.core_rst), 32'd0);
    cyc();
    chk("start_core_rst_back", 32'(bus.core_rst), 32'd1);
    ticks(SD - 1);
    chk("serve_hold", 32'(bus.state), 32'd1);
    bus.frame_tick = 1; cyc(); bus.frame_tick = 0;
    chk("launch_state", 32'(bus.state), 32'd2);
    chk("launch_vel", bus.ball_vel, 32'h00020001);

    bus.ball_pos_fb = 32'h014200F1; bus.ball_vel_fb = 32'h00020001;
    bus.frame_tick = 1; cyc(); bus.frame_tick = 0;
    chk("fb_latch", bus.ball_pos, 32'h014200F1);
    bus.btn_down = 1; ticks(200); bus.btn_down = 0;
    chk("pad_sat_low", bus.right_pad, 32'h027001A0);
    bus.btn_up = 1; ticks(3); bus.btn_up = 0;
    chk("pad_up3", bus.right_pad, 32'h02700194);

    bus.score_in = 16'h0100; cyc();
    chk("point_state", 32'(bus.state), 32'd3);
    chk("point_pos", bus.ball_pos, 32'h014000F0);
    chk("point_vel", bus.ball_vel, 32'h0);
    ticks(PD - 1);
    chk("point_hold", 32'(bus.state), 32'd3);
    bus.frame_tick = 1; cyc(); bus.frame_tick = 0;
    chk("point_to_serve", 32'(bus.state), 32'd1);
    ticks(SD - 1);
    bus.frame_tick = 1; cyc(); bus.frame_tick = 0;
    chk("serve2_vel", bus.ball_vel, 32'hFFFE0001);

    bus.score_in = 16'h010B; cyc();
    chk("win_point", 32'(bus.state), 32'd3);
    cyc();
    chk("over_state", 32'(bus.state), 32'd4);
    chk("over_winner", 32'(bus.winner), 32'd1);
    ticks(5);
    chk("over_hold", 32'(bus.state), 32'd4);
    bus.start = 1; cyc(); bus.start = 0;
    chk("restart_state", 32'(bus.state), 32'd1);
    chk("restart_core_rst", 32'(bus.core_rst), 32'd0);
    bus.score_in = 0; cyc();
    chk("restart_core_rst_back", 32'(bus.core_rst), 32'd1);

    hi = 0; lo = 0; did_rst = 0; prev_tick = 0;
    for (int c = 0; c < 15000; c++) begin
      bus.frame_tick = !prev_tick && ($urandom_range(0, 2) == 0);
      prev_tick = bus.frame_tick;
      bus.btn_up = 1'($urandom_range(0, 1));
      bus.btn_down = 1'($urandom_range(0, 1));
      bus.start = ($urandom_range(0, 7) == 0);
      bus.ball_pos_fb = $urandom;
      bus.ball_vel_fb = $urandom;
      bus.left_pad_fb = {16'd8, 16'($urandom_range(0, PMAX))};
      if (bus.core_rst == 1'b0) begin
        hi = 0; lo = 0;
      end else if (m_st == 2 && $urandom_range(0, 24) == 0) begin
        r = $urandom_range(0, 4);
        if (r == 0 || r == 2) hi++;
        if (r == 1 || r == 2) lo++;
      end
      bus.score_in = {8'(hi), 8'(lo)};
      if (!did_rst && c > 8000 && m_st == 2) begin
        rst = 1'b0; cyc(); rst = 1'b1;
        check_reset_values("midplay");
        did_rst = 1;
      end else begin
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Frame-level game controller that sits directly upstream of the ping-pong core.
- Owns the architectural game state: ball position and velocity, both paddle positions and the playfield dimensions.
- Presents that state to the core, and on each frame tick latches the core's next-state outputs back into its registers.
- Runs the serve / play / point / game-over flow, moves the human (right) paddle from buttons, and clears the core's score counter at the start of each game.

Parameters:
- FIELD_W, 640: playfield width in pixels.
- FIELD_H, 480: playfield height in pixels.
- PADDLE_LEN, 64: paddle height in pixels.
- PADDLE_STEP, 4: right-paddle move per frame tick.
- SERVE_VX, 2: serve horizontal speed magnitude.
- SERVE_VY, 1: serve vertical speed, signed.
- SERVE_DELAY, 60: frame ticks from entering SERVE to launch.
- POINT_DELAY, 30: frame ticks of pause after a point.
- WIN_SCORE, 11: score at which a game ends.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  level; begins a game when sampled in IDLE or OVER
- btn_up  in  1  right paddle up (decreasing y)
- btn_down  in  1  right paddle down (increasing y)
- score_in  in  16  core score: [15:8] upper player, [7:0] lower player
- ball_pos_fb  in  32  core next ball position
- ball_vel_fb  in  32  core next ball velocity
- left_pad_fb  in  32  core next left paddle position
- dimensions  out  32  {FIELD_W[15:0], FIELD_H[15:0]}, constant
- ball_pos  out  32  {x[31:16], y[15:0]}, unsigned
- ball_vel  out  32  {vx[31:16], vy[15:0]}, two's complement
- left_pad  out  32  {x, y_top}
- right_pad  out  32  {x, y_top}
- core_rst  out  1  active-low clear to core
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- winner  out  2  01 = lower player won, 10 = upper player won, 00 = no winner

Behaviour:
- Reset: rst is synchronous, active-low, on clk; rst low on any edge overrides everything, including mid-game. Reset values:
  - state = IDLE.
  - ball_pos = {FIELD_W/2, FIELD_H/2}; ball_vel = 0.
  - left_pad = {8, (FIELD_H-PADDLE_LEN)/2}; right_pad = {FIELD_W-16, (FIELD_H-PADDLE_LEN)/2}.
  - winner = 0; core_rst = 0; counter = 0; score shadow = 0; serve direction = positive.
- All outputs are registered; dimensions is constant. Paddle x fields never change.
- core_rst:
  - Goes 1 on the first cycle after rst is released.
  - Goes 0 for exactly one cycle on the cycle after start is accepted, then returns to 1.
- Score shadow:
  - Latches score_in every cycle. A "score event" is score_in differing from the shadow in a byte, outside the cycle in which core_rst is low.
  - Upper byte increased: next serve vx = -SERVE_VX. Lower byte increased: next serve vx = +SERVE_VX.
  - If both bytes change on the same cycle, the upper byte takes priority for direction.
- IDLE: start -> SERVE, clear counter, winner = 0, pulse core_rst.
- SERVE:
  - Ball held at centre, ball_vel = 0.
  - Counter increments on frame_tick. When counter reaches SERVE_DELAY-1 and frame_tick is high, load ball_vel = {±SERVE_VX, SERVE_VY} and go to PLAY.
- PLAY, on each frame_tick:
  - ball_pos <= ball_pos_fb; ball_vel <= ball_vel_fb; left_pad <= left_pad_fb.
  - Score event in any cycle takes priority over frame_tick: next cycle ball_pos = centre, ball_vel = 0, counter = 0, go to POINT.
- POINT:
  - Score events are ignored (the shadow still tracks score_in).
  - If either byte of score_in >= WIN_SCORE: go to OVER; winner = 10 if the upper byte qualifies, else 01.
  - Otherwise, after POINT_DELAY frame ticks, go to SERVE with counter cleared.
- OVER: all state held; start -> SERVE, same actions as from IDLE.
- Right paddle:
  - Updates on frame_tick in SERVE and PLAY only.
  - btn_up alone: y -= PADDLE_STEP, saturating at 0.
  - btn_down alone: y += PADDLE_STEP, saturating at FIELD_H-PADDLE_LEN.
  - Both or neither pressed: y held.
- Arithmetic: 16-bit fields; paddle clamping is computed in 17 bits so underflow and overflow never wrap.
- frame_tick has no effect in IDLE or OVER.

Test Plan:
- Reset then release: ball_pos = 0x014000F0, ball_vel = 0, state = 0, core_rst = 0 then 1 a cycle later.
- start in IDLE, then 60 frame_ticks: core_rst low for one cycle; state goes 1 -> 2 on tick 60; ball_vel = 0x00020001.
- In PLAY, drive ball_pos_fb = 0x01420 0F1 (x=0x0142, y=0x00F1) and pulse frame_tick: ball_pos = 0x014200F1 the next cycle; with btn_down held for 200 ticks, right_pad y saturates at 416.
- Score event with score_in 0x0000 -> 0x0100: state = 3, ball centred, vel = 0; after 30 ticks the next serve has vx = 0xFFFE.
- score_in lower byte reaches 0x0B: state = 4, winner = 01; frame_ticks produce no change; start -> state 1 and core_rst pulses.
- Assert rst low mid-PLAY for one cycle: every output returns to its reset value on the next edge.
